wrapped_mult_sequencer: RTL
===========================

WRAPPED_MULT_SEQUENCER -- requirements
Module: wrapped_mult_sequencer

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h3000_0000, the Caravel bus base of the register block.
REQ-002 SHALL have port wb_clk_i, in, 1: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port wb_rst_i, in, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i (in, 1 each), wbs_sel_i (in, 4), wbs_dat_i (in, 32) and wbs_adr_i (in, 32): the Caravel Wishbone slave request.
REQ-005 SHALL have ports wbs_ack_o (out, 1) and wbs_dat_o (out, 32): the slave response.
REQ-006 SHALL have ports rambus_wb_cyc_o, rambus_wb_stb_o, rambus_wb_we_o (out, 1 each), rambus_wb_sel_o (out, 4), rambus_wb_dat_o (out, 32) and rambus_wb_adr_o (out, 8): the shared-RAM master; the address is a word address and the wrapper appends 2'b00.
REQ-007 SHALL have ports rambus_wb_ack_i (in, 1) and rambus_wb_dat_i (in, 32): the shared-RAM response.
REQ-008 SHALL have ports mul_start_o (out, 1), mul_a_o (out, 16) and mul_b_o (out, 16): the multiplier command.
REQ-009 SHALL have ports mul_done_i (in, 1) and mul_p_i (out of the multiplier, in here, 32): the multiplier result.
REQ-010 SHALL have ports busy_o (out, 1) and done_o (out, 1): status, for debug IO.

Function
REQ-011 SHALL decode the registers at BASE_ADDRESS plus 0x00 CTRL, 0x04 SRC[7:0], 0x08 DST[7:0], 0x0C COUNT[7:0] and 0x10 PROGRESS[7:0] (read-only).
REQ-012 SHALL decode CTRL as: write bit0=1 starts a job and write bit1=1 clears done; a read returns {30'b0, done, busy}.
REQ-013 SHALL raise wbs_ack_o for exactly one cycle, one cycle after wbs_cyc_i&wbs_stb_i is first seen, and SHALL not re-ack until stb drops.
REQ-014 SHALL acknowledge unmapped in-range offsets, return 0 on reads of them, and ignore writes to them; addresses outside BASE_ADDRESS+0x00..0xFF SHALL not be acknowledged.
REQ-015 SHALL ignore writes to SRC, DST and COUNT, and any start, while busy=1; the clear-done bit SHALL always be honoured.
REQ-016 SHALL use the FSM states IDLE, RD, MSTART, MWAIT, WR and NEXT.
REQ-017 SHALL go from IDLE on start: to NEXT-complete (done=1, no bus traffic) if COUNT=0, else to RD with idx=0, busy=1 and done=0.
REQ-018 SHALL in RD hold cyc=stb=1, we=0, sel=4'hF and adr=SRC+idx (mod 256) until rambus_wb_ack_i, then latch rambus_wb_dat_i and drop cyc/stb the following cycle.
REQ-019 SHALL in MSTART pulse mul_start_o for exactly 1 cycle, with mul_a_o=word[15:0] and mul_b_o=word[31:16] held stable until mul_done_i.
REQ-020 SHALL in MWAIT wait for mul_done_i and latch mul_p_i; a mul_done_i arriving in the same cycle as the start pulse SHALL be accepted.
REQ-021 SHALL in WR hold cyc=stb=we=1, sel=4'hF, adr=DST+idx (mod 256) and dat=the latched product until ack.
REQ-022 SHALL in NEXT increment idx and PROGRESS, return to RD if idx<COUNT, else enter IDLE with busy=0 and done=1.
REQ-023 SHALL drive rambus cyc/stb and mul_start_o low in all other states; no bus request SHALL be issued on two consecutive cycles without ack.
REQ-024 SHALL let the source and destination ranges overlap; each element SHALL read before it writes, with no hazard protection beyond that ordering.
REQ-025 SHALL give a job N elements with RAM ack latency L and multiplier latency M a latency of exactly N*(2L+M+4)+1 cycles from the start ack to done=1.

Reset
REQ-026 SHALL on wb_rst_i=1, at the next edge, force all outputs, state and registers to 0 with the FSM in IDLE.
REQ-027 SHALL on wb_rst_i=1 mid-job drop cyc/stb at the next edge and discard any pending ack or mul_done_i.
REQ-028 SHALL stay inert after reset until a new start is written.

Verification
REQ-029 SHALL be covered by a register R/W test: write SRC=0x10, DST=0x40, COUNT=3 -> read back 0x10/0x40/0x03; unmapped 0x20 reads 0 with a one-cycle ack.
REQ-030 SHALL be covered by a basic job: RAM[0x10..0x12]={0x0003_0002, 0x0005_0004, 0xFFFF_FFFF}, COUNT=3, start -> RAM[0x40..0x42]={6, 20, 0xFFFE_0001}, done=1, PROGRESS=3.
REQ-031 SHALL be covered by a COUNT=0 start -> done=1 within 2 cycles and no rambus cyc.
REQ-032 SHALL be covered by a wrap test: SRC=0xFF, DST=0xFE, COUNT=2 -> reads at 0xFF then 0x00, writes at 0xFE then 0xFF.
REQ-033 SHALL be covered by a busy-write test: a mid-job write of COUNT=9 plus start -> ignored, the original job completes unchanged.
REQ-034 SHALL be covered by a reset test: wb_rst_i asserted during WR with ack withheld -> cyc/stb low the next cycle, busy=0, done=0, and a subsequent job runs correctly.

Source files
------------

// File: rtl/wrapped_mult_sequencer.sv
// wrapped_mult_sequencer
//   Wishbone-controlled job sequencer. For idx = 0..COUNT-1 it reads the word at
//   SRC+idx from a shared RAM and multiplies its low half by its high half. It then
//   writes the 32-bit product to DST+idx. RAM addresses are 8-bit word addresses
//   that wrap mod 256.
// Ports
//   wb_clk_i, wb_rst_i          : clock, synchronous active-high reset
//   wbs_*                       : Caravel Wishbone slave (register block at BASE_ADDRESS)
//                                 0x00 CTRL (w: bit0 start, bit1 clear done; r: {done, busy})
//                                 0x04 SRC, 0x08 DST, 0x0C COUNT, 0x10 PROGRESS (read-only)
//   rambus_wb_*                 : Wishbone master to the shared RAM
//   mul_start_o/a_o/b_o         : multiplier command
//   mul_done_i/mul_p_i          : multiplier result
//   busy_o, done_o              : status
module wrapped_mult_sequencer #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        rambus_wb_cyc_o,
    output logic        rambus_wb_stb_o,
    output logic        rambus_wb_we_o,
    output logic [3:0]  rambus_wb_sel_o,
    output logic [31:0] rambus_wb_dat_o,
    output logic [7:0]  rambus_wb_adr_o,
    input  logic        rambus_wb_ack_i,
    input  logic [31:0] rambus_wb_dat_i,
    output logic        mul_start_o,
    output logic [15:0] mul_a_o,
    output logic [15:0] mul_b_o,
    input  logic        mul_done_i,
    input  logic [31:0] mul_p_i,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MSTART,
        MWAIT,
        WR,
        NEXT
    } state_t;

    // Slave-side registers
    logic        r_ack;
    logic        r_seen;
    logic [31:0] r_rdata;
    logic [7:0]  r_src;
    logic [7:0]  r_dst;
    logic [7:0]  r_count;

    // Sequencer registers
    state_t      r_state;
    logic        r_start_pend;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_idx;
    logic [7:0]  r_progress;
    logic        r_cyc;
    logic        r_we;
    logic [7:0]  r_adr;
    logic [31:0] r_wdat;
    logic        r_mul_start;
    logic [15:0] r_mul_a;
    logic [15:0] r_mul_b;

    logic        w_req;
    logic        w_hit;
    logic        w_new;
    logic [7:0]  w_off;
    logic        w_wr;
    logic        w_lock;
    logic        w_ctrl_wr;
    logic        w_start;
    logic        w_clr;
    logic [7:0]  w_idx_nxt;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_req     = wbs_cyc_i & wbs_stb_i;
    assign w_hit     = w_req & (wbs_adr_i[31:8] == BASE_ADDRESS[31:8]);
    // Only the first cycle of a request is acted on; r_seen blocks re-ack until stb drops.
    assign w_new     = w_hit & ~r_seen;
    assign w_off     = wbs_adr_i[7:0];
    assign w_wr      = w_new & wbs_we_i & wbs_sel_i[0];
    // A start that is accepted but not yet picked up by the FSM already locks the config.
    assign w_lock    = r_busy | r_start_pend;
    assign w_ctrl_wr = w_wr & (w_off == 8'h00);
    assign w_start   = w_ctrl_wr & wbs_dat_i[0] & ~w_lock;
    assign w_clr     = w_ctrl_wr & wbs_dat_i[1];
    assign w_idx_nxt = r_idx + 8'd1;
    assign w_unused  = ^{wbs_sel_i[3:1], wbs_dat_i[31:8]};

    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            8'h00:   w_rdata = {30'h0, r_done, r_busy};
            8'h04:   w_rdata = {24'h0, r_src};
            8'h08:   w_rdata = {24'h0, r_dst};
            8'h0C:   w_rdata = {24'h0, r_count};
            8'h10:   w_rdata = {24'h0, r_progress};
            default: w_rdata = 32'h0;
        endcase
    end

    // Wishbone slave: registered single-cycle ack and config registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack   <= 1'b0;
            r_seen  <= 1'b0;
            r_rdata <= 32'h0;
            r_src   <= 8'h0;
            r_dst   <= 8'h0;
            r_count <= 8'h0;
        end else begin
            r_ack   <= w_new;
            r_seen  <= w_req ? (r_seen | w_hit) : 1'b0;
            r_rdata <= (w_new && !wbs_we_i) ? w_rdata : 32'h0;
            if (w_wr && !w_lock) begin
                case (w_off)
                    8'h04:   r_src   <= wbs_dat_i[7:0];
                    8'h08:   r_dst   <= wbs_dat_i[7:0];
                    8'h0C:   r_count <= wbs_dat_i[7:0];
                    default: ;
                endcase
            end
        end
    end

    // Job sequencer with registered bus/multiplier outputs
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= IDLE;
            r_start_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_idx        <= 8'h0;
            r_progress   <= 8'h0;
            r_cyc        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= 8'h0;
            r_wdat       <= 32'h0;
            r_mul_start  <= 1'b0;
            r_mul_a      <= 16'h0;
            r_mul_b      <= 16'h0;
        end else begin
            if (w_start) begin
                r_start_pend <= 1'b1;
            end
            // Clear-done is honoured even while busy; a completion on the same edge wins.
            if (w_clr) begin
                r_done <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (r_start_pend) begin
                        r_start_pend <= 1'b0;
                        r_idx        <= 8'h0;
                        r_progress   <= 8'h0;
                        if (r_count == 8'h0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b0;
                            r_adr   <= r_src;
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    if (rambus_wb_ack_i) begin
                        r_cyc       <= 1'b0;
                        r_mul_start <= 1'b1;
                        r_mul_a     <= rambus_wb_dat_i[15:0];
                        r_mul_b     <= rambus_wb_dat_i[31:16];
                        r_state     <= MSTART;
                    end
                end
                MSTART, MWAIT: begin
                    r_mul_start <= 1'b0;
                    if (mul_done_i) begin
                        r_wdat  <= mul_p_i;
                        r_cyc   <= 1'b1;
                        r_we    <= 1'b1;
                        r_adr   <= r_dst + r_idx;
                        r_state <= WR;
                    end else begin
                        r_state <= MWAIT;
                    end
                end
                WR: begin
                    if (rambus_wb_ack_i) begin
                        r_cyc   <= 1'b0;
                        r_we    <= 1'b0;
                        r_state <= NEXT;
                    end
                end
                NEXT: begin
                    r_idx      <= w_idx_nxt;
                    r_progress <= r_progress + 8'd1;
                    if (w_idx_nxt < r_count) begin
                        r_cyc   <= 1'b1;
                        r_adr   <= r_src + w_idx_nxt;
                        r_state <= RD;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wbs_ack_o       = r_ack;
    assign wbs_dat_o       = r_rdata;
    assign rambus_wb_cyc_o = r_cyc;
    assign rambus_wb_stb_o = r_cyc;
    assign rambus_wb_we_o  = r_we;
    assign rambus_wb_sel_o = r_cyc ? 4'hF : 4'h0;
    assign rambus_wb_dat_o = r_wdat;
    assign rambus_wb_adr_o = r_adr;
    assign mul_start_o     = r_mul_start;
    assign mul_a_o         = r_mul_a;
    assign mul_b_o         = r_mul_b;
    assign busy_o          = r_busy;
    assign done_o          = r_done;

endmodule
